// File: rtl/dyt_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the default address/data widths, the register count derived from
// the address width, and the requester-ID encoding used by the round-robin
// arbiter (A = ALU = 0, B = load unit = 1).
package dyt_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/dyt_rr_arb2.sv
// Two-input round-robin arbiter.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   a_valid, b_valid    request lines of requester A and requester B
//   a_grant, b_grant    combinational grants, at most one high per cycle
// A lone requester is granted immediately. Under contention the requester
// that did not win the last transfer is granted. The last-grant flop only
// moves when a grant is actually taken (grant implies valid, so every grant
// is a transfer). Reset leaves last_grant at B so A wins the first contention.
module dyt_rr_arb2
    import dyt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a_valid,
    input  logic b_valid,
    output logic a_grant,
    output logic b_grant
);

    req_id_t last_grant;

    // Grants are suppressed while reset is held so nothing can be accepted
    // into a register that is being cleared.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (rst) begin
            if (a_valid && b_valid) begin
                a_grant = (last_grant == REQ_B);
                b_grant = (last_grant == REQ_A);
            end else begin
                a_grant = a_valid;
                b_grant = b_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= REQ_B;
        end else if (a_grant) begin
            last_grant <= REQ_A;
        end else if (b_grant) begin
            last_grant <= REQ_B;
        end
    end

endmodule

// File: rtl/dyt_rf_wb_arbiter.sv
// Register-file writeback arbiter with pending-write scoreboard.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   a_valid/a_addr/a_data, a_ready ALU writeback request and acceptance
//   b_valid/b_addr/b_data, b_ready load-unit writeback request and acceptance
//   iss_en/iss_addr                issue marks a destination register pending
//   r_a_addr, r_b_addr             source addresses under hazard check
//   haz_a, haz_b                   source has a pending write
//   w_en/w_addr/w_data             registered register-file write port
// One writeback is accepted per cycle and appears on the write port the
// following cycle. Register 0 is constant zero: writes to it are accepted
// but never reach the write port and it is never marked pending.
module dyt_rf_wb_arbiter #(
    parameter int ADDR_WIDTH = dyt_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = dyt_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    input  logic                  iss_en,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    input  logic [ADDR_WIDTH-1:0] r_a_addr,
    input  logic [ADDR_WIDTH-1:0] r_b_addr,
    output logic                  haz_a,
    output logic                  haz_b,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_WORDS-1:0]  busy;
    logic [NUM_WORDS-1:0]  busy_next;

    dyt_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .b_valid (b_valid),
        .a_grant (a_ready),
        .b_grant (b_ready)
    );

    // Grants are one-hot and imply valid, so the winner's fields are the
    // transfer payload whenever xfer is high.
    assign xfer     = a_ready | b_ready;
    assign sel_addr = a_ready ? a_addr : b_addr;
    assign sel_data = a_ready ? a_data : b_data;

    // A transfer to register 0 is swallowed: accepted, but w_en stays low and
    // the port keeps its previous address/data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else if (xfer && (sel_addr != '0)) begin
            w_en   <= 1'b1;
            w_addr <= sel_addr;
            w_data <= sel_data;
        end else begin
            w_en   <= 1'b0;
        end
    end

    // Clear is applied before set so an issue to the register being written
    // back in the same cycle keeps it pending.
    always_comb begin
        busy_next = busy;
        if (w_en) begin
            busy_next[w_addr] = 1'b0;
        end
        if (iss_en) begin
            busy_next[iss_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign haz_a = busy[r_a_addr];
    assign haz_b = busy[r_b_addr];

endmodule

// File: doc/dyt_rf_wb_arbiter.md
DYT_RF_WB_ARBITER -- requirements
Module: dyt_rf_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, register address width (16 registers, x0 constant zero).
REQ-002 Parameter DATA_WIDTH, default 32, writeback data width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 a_valid/a_addr/a_data  in  1/ADDR_WIDTH/DATA_WIDTH  ALU writeback request.
REQ-006 a_ready  out  1  ALU request accepted this cycle.
REQ-007 b_valid/b_addr/b_data  in  1/ADDR_WIDTH/DATA_WIDTH  load-unit writeback request.
REQ-008 b_ready  out  1  load request accepted this cycle.
REQ-009 iss_en/iss_addr  in  1/ADDR_WIDTH  issue stage marks destination register pending.
REQ-010 r_a_addr, r_b_addr  in  ADDR_WIDTH each  source addresses under hazard check.
REQ-011 haz_a, haz_b  out  1 each  source register has a pending write.
REQ-012 w_en/w_addr/w_data  out  1/ADDR_WIDTH/DATA_WIDTH  register-file write port drive.

Function
REQ-013 Handshake: request transfers when valid and ready both high at a rising edge; valid, addr, data stay stable until transfer.
REQ-014 ready is combinational from valids and arbitration state only; at most one of a_ready/b_ready high per cycle.
REQ-015 Single requester valid: that requester gets ready in the same cycle.
REQ-016 Both valid: round-robin -- grant the requester not granted on the last transfer; last_grant flop updates only on transfer.
REQ-017 Write port registered: transfer at edge N drives w_en=1, w_addr, w_data for cycle N+1; one transfer per cycle, no back-pressure from the register file.
REQ-018 No transfer at edge N: w_en=0 in cycle N+1; w_addr/w_data hold last value.
REQ-019 Transfer with addr 0: accepted (ready high), w_en stays 0, no scoreboard change.
REQ-020 Scoreboard: busy vector, one bit per register 1..NUM_WORDS-1; bit 0 hardwired 0.
REQ-021 iss_en with nonzero iss_addr sets busy[iss_addr] at the edge.
REQ-022 Edge where w_en=1 clears busy[w_addr] (same edge the register file writes).
REQ-023 Set and clear of same register at same edge: set wins.
REQ-024 haz_a = busy[r_a_addr], haz_b = busy[r_b_addr], combinational from registered busy; address 0 never hazards.
REQ-025 Writeback to non-busy register is legal: written normally, busy unchanged.

Reset
REQ-026 rst low: w_en=0, w_addr=0, w_data=0, busy all 0, last_grant=B (A wins first contention), asynchronously.
REQ-027 rst low mid-transfer: pending registered write discarded; a_ready/b_ready forced 0 while rst low.
REQ-028 First handshake possible at first rising edge after rst deasserts.

Structure
REQ-029 ADDR_WIDTH, NUM_WORDS (2**ADDR_WIDTH), DATA_WIDTH defaults and requester-ID encoding (A=0, B=1) in shared package dyt_pkg.
REQ-030 One sub-module, dyt_rr_arb2: two-input round-robin arbiter holding last_grant; scoreboard and write-port register stay in top.

Verification
REQ-031 a_valid=1 a_addr=5 a_data=0xDEADBEEF alone -> a_ready same cycle; next cycle w_en=1 w_addr=5 w_data=0xDEADBEEF.
REQ-032 Both valid every cycle for 4 cycles (a_addr=1, b_addr=2) out of reset -> grants A,B,A,B; w_addr sequence 1,2,1,2.
REQ-033 iss_en addr 7, then r_a_addr=7 -> haz_a=1 from next cycle until edge after w_en with w_addr=7, then haz_a=0.
REQ-034 iss_en addr 3 on the edge where w_en=1 w_addr=3 -> busy[3] remains 1, haz on 3 stays high.
REQ-035 b_valid=1 b_addr=0 -> b_ready=1, w_en stays 0; iss_en addr 0 -> haz on addr 0 always 0.
REQ-036 rst low one cycle after a transfer -> w_en=0 immediately, busy cleared, first post-reset contention granted to A.
